// File: rtl/fir_fp_pkg.sv
// Shared definitions for the FIR floating-point output path.
// Holds the FP29i field layout, FP16 constants and the output-stage FSM
// state encoding used by fir_fp16_out_pack and fp16_rne_round.
package fir_fp_pkg;

    // FP29i: {sgn, exp[6:0], man[21:0]}, unsigned magnitude, unnormalized
    localparam int FP29_MAN_W   = 22;
    localparam int FP29_EXP_W   = 7;
    localparam int FP29_W       = 1 + FP29_EXP_W + FP29_MAN_W;
    localparam int FP29_MAN_LSB = 0;
    localparam int FP29_EXP_LSB = FP29_MAN_W;
    localparam int FP29_SGN_BIT = FP29_MAN_W + FP29_EXP_W;

    localparam int EBIAS_IN_DEF = 63;
    localparam int FRAC_IN_DEF  = 20;

    // FP16
    localparam int          FP16_BIAS    = 15;
    localparam int          FP16_EXP_MAX = 31;
    localparam int          FP16_FRAC_W  = 10;
    localparam logic [14:0] FP16_INF_MAG = 15'h7C00;
    localparam logic [14:0] FP16_ZERO    = 15'h0000;

    // Working exponent width (signed)
    localparam int E_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_RND  = 2'd2,
        ST_OUT  = 2'd3
    } out_state_t;

endpackage

// File: rtl/fp16_rne_round.sv
// Round-to-nearest-even of a normalized 22-bit mantissa down to the
// 10-bit FP16 fraction.
// Ports:
//   man     in  22  normalized mantissa (hidden one at bit 21, or zero)
//   exp_in  in  10  signed biased FP16 exponent before rounding
//   frac    out 10  rounded fraction
//   exp_adj out 10  exponent, incremented when rounding carries out of frac
module fp16_rne_round
    import fir_fp_pkg::*;
(
    input  logic [FP29_MAN_W-1:0] man,
    input  logic [E_W-1:0]        exp_in,
    output logic [9:0]            frac,
    output logic [E_W-1:0]        exp_adj
);

    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [10:0] frac_sum;

    assign guard    = man[10];
    assign sticky   = |man[9:0];
    assign round_up = guard & (sticky | man[11]);
    assign frac_sum = {1'b0, man[20:11]} + {10'b0, round_up};

    // On carry-out the fraction wraps to zero and the hidden one moves up.
    assign frac    = frac_sum[9:0];
    assign exp_adj = exp_in + {{(E_W-1){1'b0}}, frac_sum[10]};

endmodule

// File: rtl/fir_fp16_out_pack.sv
// FIR output stage: normalizes one FP29i sum, rounds it to FP16 (RNE),
// saturates to Inf / flushes to zero, and holds dout with a stretched
// valid so a slower domain can sample it.
// Ports:
//   clk_fast  in   fast clock
//   rst_n     in   async active-low reset
//   in_valid  in   1-cycle strobe for in_fp29i
//   in_fp29i  in   {sgn, exp[6:0], man[21:0]}
//   clr_err   in   sync clear of sticky flags (a same-cycle set wins)
//   in_ready  out  high only in IDLE
//   dout      out  FP16 result, stable between updates
//   valid     out  high VALID_HOLD cycles after each new dout
//   busy      out  ~in_ready
//   ovf       out  sticky: result saturated to +/-Inf
//   unf       out  sticky: nonzero result flushed to zero
//   drop_err  out  sticky: input arrived while busy and was discarded
//
// state   | meaning
// IDLE    | waiting for in_valid, in_ready high
// NORM    | shifting mantissa left until bit 21 is set (or it is zero)
// RND     | rounding normalized mantissa, result registered
// OUT     | range check; dout/valid/flags update on the edge leaving OUT
module fir_fp16_out_pack
    import fir_fp_pkg::*;
#(
    parameter int EBIAS_IN   = EBIAS_IN_DEF,
    parameter int FRAC_IN    = FRAC_IN_DEF,
    parameter int VALID_HOLD = 8
) (
    input  logic              clk_fast,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [FP29_W-1:0] in_fp29i,
    input  logic              clr_err,
    output logic              in_ready,
    output logic [15:0]       dout,
    output logic              valid,
    output logic              busy,
    output logic              ovf,
    output logic              unf,
    output logic              drop_err
);

    // Constant part of the exponent rebias; may be negative, wraps in 10b.
    localparam logic [E_W-1:0] E_OFS =
        E_W'(FP16_BIAS + FP29_MAN_W - 1 - EBIAS_IN - FRAC_IN);
    localparam logic signed [E_W-1:0] E_MAX_S = E_W'(FP16_EXP_MAX);
    localparam logic [7:0]            HOLD_LD = 8'(VALID_HOLD);

    out_state_t state, state_nxt;

    logic                  sgn_r;
    logic [FP29_EXP_W-1:0] exp_r;
    logic [FP29_MAN_W-1:0] man_r;
    logic [4:0]            k_r;
    logic [9:0]            frac_r;
    logic [E_W-1:0]        e16_r;
    logic [7:0]            hold_cnt;

    logic                  norm_done;
    logic [E_W-1:0]        e_pre;
    logic [9:0]            rnd_frac;
    logic [E_W-1:0]        rnd_exp;

    logic                  accept;
    logic                  out_fire;
    logic [15:0]           res_word;
    logic                  res_ovf;
    logic                  res_unf;

    assign norm_done = man_r[FP29_MAN_W-1] | (man_r == '0);
    assign e_pre     = {{(E_W-FP29_EXP_W){1'b0}}, exp_r} + E_OFS
                       - {{(E_W-5){1'b0}}, k_r};

    fp16_rne_round u_round (
        .man     (man_r),
        .exp_in  (e_pre),
        .frac    (rnd_frac),
        .exp_adj (rnd_exp)
    );

    // State register
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (in_valid) state_nxt = ST_NORM;
            ST_NORM: if (norm_done) state_nxt = ST_RND;
            ST_RND:  state_nxt = ST_OUT;
            ST_OUT:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        in_ready = (state == ST_IDLE);
        busy     = (state != ST_IDLE);
        accept   = (state == ST_IDLE) & in_valid;
        out_fire = (state == ST_OUT);
        valid    = (hold_cnt != 8'd0);

        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        if (man_r == '0) begin
            res_word = {sgn_r, FP16_ZERO};
        end else if ($signed(e16_r) >= E_MAX_S) begin
            res_word = {sgn_r, FP16_INF_MAG};
            res_ovf  = 1'b1;
        end else if ($signed(e16_r) <= $signed(E_W'(0))) begin
            res_word = {sgn_r, FP16_ZERO};
            res_unf  = 1'b1;
        end else begin
            res_word = {sgn_r, e16_r[4:0], frac_r};
        end
    end

    // Datapath: capture, normalize, round
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            sgn_r  <= 1'b0;
            exp_r  <= '0;
            man_r  <= '0;
            k_r    <= '0;
            frac_r <= '0;
            e16_r  <= '0;
        end else begin
            if (accept) begin
                sgn_r <= in_fp29i[FP29_SGN_BIT];
                exp_r <= in_fp29i[FP29_EXP_LSB +: FP29_EXP_W];
                man_r <= in_fp29i[FP29_MAN_LSB +: FP29_MAN_W];
                k_r   <= '0;
            end
            if (state == ST_NORM && !norm_done) begin
                man_r <= man_r << 1;
                k_r   <= k_r + 5'd1;
            end
            if (state == ST_RND) begin
                frac_r <= rnd_frac;
                e16_r  <= rnd_exp;
            end
        end
    end

    // Output register and valid stretch
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= 16'h0000;
            hold_cnt <= 8'd0;
        end else if (out_fire) begin
            dout     <= res_word;
            hold_cnt <= HOLD_LD;
        end else if (hold_cnt != 8'd0) begin
            hold_cnt <= hold_cnt - 8'd1;
        end
    end

    // Sticky flags: set beats clear
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            unf      <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            ovf      <= (out_fire & res_ovf) | (ovf & ~clr_err);
            unf      <= (out_fire & res_unf) | (unf & ~clr_err);
            drop_err <= (in_valid & busy) | (drop_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_fir_fp16_out_pack.sv
module tb_fir_fp16_out_pack;

    localparam int VH = 8;

    logic        clk_fast = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [29:0] in_fp29i;
    logic        clr_err;
    logic        in_ready;
    logic [15:0] dout;
    logic        valid;
    logic        busy;
    logic        ovf;
    logic        unf;
    logic        drop_err;

    int vectors     = 0;
    int miscompares = 0;
    bit m_ovf, m_unf, m_drop;

    fir_fp16_out_pack #(.VALID_HOLD(VH)) dut (
        .clk_fast (clk_fast),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_fp29i (in_fp29i),
        .clr_err  (clr_err),
        .in_ready (in_ready),
        .dout     (dout),
        .valid    (valid),
        .busy     (busy),
        .ovf      (ovf),
        .unf      (unf),
        .drop_err (drop_err)
    );

    always #5 clk_fast = ~clk_fast;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: value = m * 2^(e-83); find leading one, round the scaled
    // magnitude to an 11-bit significand with ties to even, then range check.
    function automatic void model(input logic s, input logic [6:0] e,
                                  input logic [21:0] m, output logic [15:0] d,
                                  output bit ov, output bit un, output int lat);
        int     p;
        int     ex;
        longint q, r, half;
        ov = 0;
        un = 0;
        if (m == 22'd0) begin
            d   = {s, 15'h0000};
            lat = 3;
            return;
        end
        p = 21;
        while (m[p] == 1'b0) p--;
        lat = (21 - p) + 3;
        ex  = int'(e) - 63 - 20 + p + 15;
        if (p > 10) begin
            q    = longint'(m) >> (p - 10);
            r    = longint'(m) - (q << (p - 10));
            half = longint'(1) << (p - 11);
            if (r > half || (r == half && q[0])) q++;
        end else begin
            q = longint'(m) << (10 - p);
        end
        if (q == 2048) begin
            q = 1024;
            ex++;
        end
        if (ex >= 31) begin
            d  = {s, 15'h7C00};
            ov = 1;
        end else if (ex <= 0) begin
            d  = {s, 15'h0000};
            un = 1;
        end else begin
            d = {s, 5'(ex), 10'(q)};
        end
    endfunction

    // Apply one input, check exact latency, result, flags and valid stretch.
    // inject_at > 0 drives a spurious in_valid at that edge after accept.
    task automatic run_vec(input string tag, input logic s, input logic [6:0] e,
                           input logic [21:0] m, input int inject_at);
        logic [15:0] exp_d;
        bit ov, un;
        int lat;
        model(s, e, m, exp_d, ov, un, lat);
        @(negedge clk_fast);
        in_valid = 1'b1;
        in_fp29i = {s, e, m};
        @(posedge clk_fast);
        #1;
        chk({tag, ":ready_after_accept"}, 16'(in_ready), 16'd0);
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk_fast);
            in_valid = (n == inject_at);
            if (n == inject_at) in_fp29i = 30'($urandom);
            @(posedge clk_fast);
            #1;
            if (n == lat - 1) chk({tag, ":valid_early"}, 16'(valid), 16'd0);
        end
        if (inject_at > 0) m_drop = 1;
        m_ovf = m_ovf | ov;
        m_unf = m_unf | un;
        chk({tag, ":dout"}, dout, exp_d);
        chk({tag, ":valid_rise"}, 16'(valid), 16'd1);
        chk({tag, ":ovf"}, 16'(ovf), 16'(m_ovf));
        chk({tag, ":unf"}, 16'(unf), 16'(m_unf));
        chk({tag, ":drop_err"}, 16'(drop_err), 16'(m_drop));
        @(negedge clk_fast);
        in_valid = 1'b0;
        for (int n = 1; n <= VH; n++) begin
            @(posedge clk_fast);
            #1;
            if (n == 1) chk({tag, ":ready_idle"}, 16'(in_ready), 16'd1);
            if (n == VH - 1) chk({tag, ":valid_hold"}, 16'(valid), 16'd1);
            if (n == VH) begin
                chk({tag, ":valid_fall"}, 16'(valid), 16'd0);
                chk({tag, ":dout_kept"}, dout, exp_d);
            end
        end
    endtask

    task automatic clear_flags(input string tag);
        @(negedge clk_fast);
        clr_err = 1'b1;
        @(posedge clk_fast);
        #1;
        clr_err = 1'b0;
        m_ovf = 0;
        m_unf = 0;
        m_drop = 0;
        chk({tag, ":ovf_clr"}, 16'(ovf), 16'd0);
        chk({tag, ":unf_clr"}, 16'(unf), 16'd0);
        chk({tag, ":drop_clr"}, 16'(drop_err), 16'd0);
    endtask

    initial begin
        logic        rs;
        logic [6:0]  re;
        logic [21:0] rm;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_fp29i = '0;
        clr_err  = 1'b0;
        m_ovf = 0;
        m_unf = 0;
        m_drop = 0;
        #1;
        chk("rst:dout", dout, 16'h0000);
        chk("rst:valid", 16'(valid), 16'd0);
        chk("rst:in_ready", 16'(in_ready), 16'd1);
        chk("rst:busy", 16'(busy), 16'd0);
        chk("rst:flags", 16'({ovf, unf, drop_err}), 16'd0);
        repeat (2) @(negedge clk_fast);
        rst_n = 1'b1;

        run_vec("one", 1'b0, 7'd63, 22'h100000, 0);
        run_vec("neg3", 1'b1, 7'd63, 22'h300000, 0);
        run_vec("tie_even", 1'b0, 7'd62, 22'h200400, 0);
        run_vec("tie_odd", 1'b0, 7'd62, 22'h200C00, 0);
        run_vec("carry", 1'b0, 7'd62, 22'h3FFC00, 0);
        run_vec("ovf_pos", 1'b0, 7'd127, 22'h200000, 0);
        run_vec("ovf_neg", 1'b1, 7'd127, 22'h200000, 0);
        clear_flags("clr1");
        run_vec("neg_zero", 1'b1, 7'd40, 22'h000000, 0);
        run_vec("unf", 1'b0, 7'd0, 22'h000001, 0);
        clear_flags("clr2");
        run_vec("drop", 1'b0, 7'd63, 22'h100000, 2);
        run_vec("drop_out_edge", 1'b0, 7'd63, 22'h300000, 3);
        clear_flags("clr3");

        // Reset in the middle of a long normalization
        @(negedge clk_fast);
        in_valid = 1'b1;
        in_fp29i = {1'b0, 7'd0, 22'h000001};
        @(negedge clk_fast);
        in_valid = 1'b0;
        repeat (4) @(negedge clk_fast);
        rst_n = 1'b0;
        #1;
        chk("midrst:valid", 16'(valid), 16'd0);
        chk("midrst:dout", dout, 16'h0000);
        chk("midrst:in_ready", 16'(in_ready), 16'd1);
        @(negedge clk_fast);
        rst_n = 1'b1;
        m_ovf = 0;
        m_unf = 0;
        m_drop = 0;
        run_vec("after_rst", 1'b0, 7'd63, 22'h100000, 0);

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom);
            re = 7'($urandom_range(30, 100));
            rm = 22'($urandom) >> $urandom_range(0, 21);
            if (i % 8 == 0) re = 7'($urandom);
            run_vec("rand", rs, re, rm, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
